// File: rtl/fetch_queue_stage_pkg.sv
// Shared constants and queue entry type for the fetch/queue stage.
// Default widths and the NOP encoding match the global pipeline definitions.
package fetch_queue_stage_pkg;

   localparam int FQ_PC_WIDTH = 16;
   localparam int FQ_IR_WIDTH = 32;
   localparam logic [FQ_IR_WIDTH-1:0] FQ_NOP_IR = 32'hFF000000;

   typedef struct packed {
      logic [FQ_PC_WIDTH-1:0] pc;
      logic [FQ_IR_WIDTH-1:0] ir;
   } fqEntry_t;

   function automatic int fqCountWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// Prefetch FIFO: push/pop/flush with full/empty/count; all state moves on the
// falling clock edge to line up with the rest of the fetch stage.
module fetch_prefetch_fifo
   import fetch_queue_stage_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type ENTRY_T = fqEntry_t
) (
   input  logic                      clk,
   input  logic                      rstN,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      flush,
   input  ENTRY_T                    pushData,
   output ENTRY_T                    headData,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);

   ENTRY_T         mem [DEPTH];
   logic [PW-1:0]  wrPtr;
   logic [PW-1:0]  rdPtr;
   logic           doPush;
   logic           doPop;

   assign full     = (count == (PW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign doPop    = pop & ~flush & ~empty;
   // A push into a full queue is legal when the head leaves in the same cycle.
   assign doPush   = push & ~flush & (~full | doPop);
   assign headData = mem[rdPtr];

   always_ff @(negedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

   always_ff @(negedge clk or negedge rstN) begin
      if (!rstN) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         if (doPush && !doPop)      count <= count + 1'b1;
         else if (!doPush && doPop) count <= count - 1'b1;
      end
   end

   countRange: assert property (@(negedge clk) disable iff (!rstN)
      count <= (PW+1)'(DEPTH));

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage with a prefetch queue feeding the FE/DE latch; redirects flush it.
// Define FETCH_BYPASS_EN to send the memory word straight to FE/DE when the queue is empty.
module fetch_queue_stage
   import fetch_queue_stage_pkg::*;
#(
   parameter int                   PC_WIDTH    = FQ_PC_WIDTH,
   parameter int                   IR_WIDTH    = FQ_IR_WIDTH,
   parameter int                   IMEM_DEPTH  = 1024,
   parameter int                   QUEUE_DEPTH = 4,
   parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
   parameter logic [IR_WIDTH-1:0]  NOP_IR      = IR_WIDTH'(FQ_NOP_IR),
   parameter string                INIT_FILE   = "test0.hex"
) (
   input  logic                                I_CLOCK,
   input  logic                                I_RESET_N,
   input  logic                                I_LOCK,
   input  logic [PC_WIDTH-1:0]                 I_BranchPC,
   input  logic                                I_BranchAddrSelect,
   input  logic                                I_BranchStallSignal,
   input  logic                                I_DepStallSignal,
   output logic                                O_LOCK,
   output logic [PC_WIDTH-1:0]                 O_PC,
   output logic [IR_WIDTH-1:0]                 O_IR,
   output logic                                O_FetchStall,
   output logic [$clog2(QUEUE_DEPTH):0]        O_QueueCount
);

   localparam int AW = $clog2(IMEM_DEPTH);

   // Same layout as fqEntry_t, sized to this instance's widths.
   typedef struct packed {
      logic [PC_WIDTH-1:0] pc;
      logic [IR_WIDTH-1:0] ir;
   } qEntry_t;

   // Image named by INIT_FILE is preloaded into instMem by the environment.
   logic [IR_WIDTH-1:0] instMem [IMEM_DEPTH];

   logic [PC_WIDTH-1:0] fpc;
   logic [PC_WIDTH-1:0] fpcInc;
   logic [PC_WIDTH-1:0] branchTarget;
   logic [IR_WIDTH-1:0] memWord;
   qEntry_t             pushEntry;
   qEntry_t             headEntry;
   logic                qFull;
   logic                qEmpty;
   logic                stall;
   logic                run;
   logic                flush;
   logic                doPop;
   logic                doPush;
   logic                doBypass;

   assign memWord      = instMem[fpc[AW+1:2]];
   assign fpcInc       = fpc + PC_WIDTH'(4);
   assign branchTarget = I_BranchPC & ~PC_WIDTH'(3);
   assign pushEntry    = '{pc: fpcInc, ir: memWord};

   // Lock-low and redirect both discard the queue and block push/pop.
   always_comb begin
      stall  = I_BranchStallSignal | I_DepStallSignal;
      run    = I_LOCK & ~I_BranchAddrSelect;
      flush  = ~run;
      doPop  = run & ~stall & ~qEmpty;
`ifdef FETCH_BYPASS_EN
      doBypass = run & ~stall & qEmpty;
`else
      doBypass = 1'b0;
`endif
      doPush = run & ~doBypass & (~qFull | doPop);
   end

   fetch_prefetch_fifo #(
      .DEPTH   (QUEUE_DEPTH),
      .ENTRY_T (qEntry_t)
   ) uFifo (
      .clk      (I_CLOCK),
      .rstN     (I_RESET_N),
      .push     (doPush),
      .pop      (doPop),
      .flush    (flush),
      .pushData (pushEntry),
      .headData (headEntry),
      .full     (qFull),
      .empty    (qEmpty),
      .count    (O_QueueCount)
   );

   always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N)                fpc <= RESET_PC;
      else if (!I_LOCK)              fpc <= RESET_PC;
      else if (I_BranchAddrSelect)   fpc <= branchTarget;
      else if (doPush || doBypass)   fpc <= fpcInc;
   end

   // FE/DE latch: anything other than a pop or bypass leaves a bubble.
   always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         O_LOCK       <= 1'b0;
         O_PC         <= '0;
         O_IR         <= NOP_IR;
         O_FetchStall <= 1'b1;
      end else begin
         O_LOCK       <= I_LOCK;
         O_FetchStall <= 1'b1;
         if (doPop) begin
            O_PC         <= headEntry.pc;
            O_IR         <= headEntry.ir;
            O_FetchStall <= 1'b0;
         end else if (doBypass) begin
            O_PC         <= fpcInc;
            O_IR         <= memWord;
            O_FetchStall <= 1'b0;
         end
      end
   end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised next-generation fetch stage for the in-order pipeline. It decouples instruction-memory reads from decode using a QUEUE_DEPTH-entry prefetch queue, so fetch keeps running through decode stalls. Branch redirects from memory flush the queue. It drives the FE/DE latch (O_PC, O_IR, O_FetchStall) into the decode stage.

Parameters:
PC_WIDTH, 16, PC/address width in bits
IR_WIDTH, 32, instruction width
IMEM_DEPTH, 1024, instruction memory words (power of 2)
QUEUE_DEPTH, 4, prefetch queue entries (power of 2, >=2)
RESET_PC, 0, PC after reset or lock release
NOP_IR, 32'hFF000000, O_IR value on reset
INIT_FILE, "test0.hex", $readmemh image for instruction memory

Ports:
I_CLOCK  in  1  clock; all state updates on negedge
I_RESET_N  in  1  asynchronous active-low reset
I_LOCK  in  1  pipeline run enable; 0 = soft restart
I_BranchPC  in  PC_WIDTH  branch target from memory stage
I_BranchAddrSelect  in  1  redirect strobe, one cycle
I_BranchStallSignal  in  1  decode: branch unresolved, hold FE/DE
I_DepStallSignal  in  1  decode: register dependency, hold FE/DE
O_LOCK  out  1  I_LOCK registered
O_PC  out  PC_WIDTH  address of O_IR + 4
O_IR  out  IR_WIDTH  instruction to decode
O_FetchStall  out  1  1 = FE/DE content is a bubble (NOP downstream)
O_QueueCount  out  log2(QUEUE_DEPTH)+1  current queue occupancy

Behaviour:
- Async reset (I_RESET_N=0): O_LOCK=0, O_PC=0, O_IR=NOP_IR, O_FetchStall=1, queue empty, count=0, fetch PC (FPC)=RESET_PC.
- I_LOCK=0 at negedge: flush queue, FPC<=RESET_PC, O_FetchStall<=1, O_PC/O_IR hold. O_LOCK<=I_LOCK every edge.
- Instruction read is combinational: word InstMem[FPC[AW+1:2]], AW=log2(IMEM_DEPTH); upper FPC bits are ignored (address aliasing).
- Push: lock=1, no redirect, queue not full (or full with a pop in the same cycle) -> enqueue {FPC+4, word}; FPC<=FPC+4, wrapping mod 2^PC_WIDTH.
- Pop: lock=1, no redirect, stall=(Branch|Dep)=0, queue non-empty -> O_PC/O_IR<=head; O_FetchStall<=0.
- stall=1: O_PC/O_IR hold; O_FetchStall<=1; queue keeps filling until full.
- stall=0 and queue empty: bubble, O_FetchStall<=1, outputs hold.
- Simultaneous push and pop: count unchanged; pointers both advance.
- Full with no pop: FPC holds, no write.
- Redirect (I_BranchAddrSelect=1) has priority over everything except reset and I_LOCK=0. Queue flushes, FPC<=I_BranchPC with bits[1:0] forced to 0, O_FetchStall<=1, and no push or pop that cycle.
- Latency without bypass: a word pushed at edge N reaches O_IR at edge N+1 at the earliest. First valid output after lock rises comes 2 edges later.
- Pointers are log2(QUEUE_DEPTH) bits and wrap naturally. Count saturates neither way; it is asserted 0..QUEUE_DEPTH.

Optional Feature:
FETCH_BYPASS_EN. Defined: when the queue is empty, stall=0, lock=1 and there is no redirect, the current memory word goes directly to O_PC/O_IR with O_FetchStall<=0. FPC advances and nothing is enqueued. Fetch-to-decode latency becomes 1 edge. Undefined: the path always goes through the queue with latency 2.

Decomposition:
- Shared package/header holds the constants PC_WIDTH/IR_WIDTH defaults, NOP_IR, and the queue entry struct {pc, ir}. These stay consistent with the existing global definitions header.
- One sub-module, fetch_prefetch_fifo: a parametrised synchronous FIFO with push/pop/flush, full/empty/count and async active-low reset. The top level owns FPC, redirect priority and output registers.

Test Plan:
- Reset then lock=1, no stalls, imem words 0..7 = A0..A7 -> O_IR=A0 with O_PC=4 two edges after lock, then A1,A2... one per edge, O_FetchStall=0.
- Hold DepStall for 6 edges mid-stream -> O_PC/O_IR frozen, O_FetchStall=1, O_QueueCount climbs to 4 and stops, FPC frozen. On release, drain continues in order with no gap.
- BranchAddrSelect with I_BranchPC=0x0022 while the queue holds 3 entries -> count=0, bubble that edge, next valid O_IR=InstMem[8], O_PC=0x0024.
- Redirect and DepStall asserted together -> redirect wins: flush occurs, FPC=0x0020.
- FPC=0xFFFC with a free run -> wraps to 0x0000, O_PC sequence 0x0000 then 0x0004.
- I_RESET_N pulsed low between edges mid-run -> outputs immediately return to reset values, with no clock edge needed. With FETCH_BYPASS_EN, the first valid O_IR appears 1 edge after lock.
